// File: rtl/meas_sequencer.sv
// Demodulation measurement sequencer: trigger, settle, capture judge flags,
// classify modulation and publish one registered result set per campaign.
module meas_sequencer #(
  parameter int IO_width   = 14,
  parameter int CNT_WIDTH  = 32,
  parameter int SETTLE_NUM = 36000,
  parameter int HOLD_NUM   = 18000,
  parameter int PSK_DL     = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       auto_en,
  input  logic                       abort,
  input  logic                       A_const,
  input  logic                       A_square,
  input  logic                       Freq_const,
  input  logic                       Freq_square,
  input  logic signed [IO_width-1:0] A_max,
  input  logic signed [IO_width-1:0] A_min,
  input  logic signed [IO_width-1:0] A_edge_interv_homo,
  input  logic signed [IO_width-1:0] A_freq,
  input  logic signed [IO_width-1:0] F_freq,
  output logic                       meas_trig,
  output logic                       busy,
  output logic [2:0]                 mod_type,
  output logic signed [IO_width-1:0] mod_freq,
  output logic signed [IO_width:0]   amp_pp,
  output logic                       result_valid
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, CAPTURE, DONE} state_t;

  localparam logic [2:0] MT_CW = 3'd0, MT_AM = 3'd1, MT_ASK = 3'd2,
                         MT_FM = 3'd3, MT_FSK = 3'd4, MT_PSK = 3'd5,
                         MT_UNK = 3'd7;

  localparam logic [CNT_WIDTH-1:0] SETTLE_TC = CNT_WIDTH'(SETTLE_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_TC   = CNT_WIDTH'(HOLD_NUM - 1);
  localparam logic signed [IO_width-1:0] PSK_TH = IO_width'(PSK_DL);

  state_t                      state;
  logic [CNT_WIDTH-1:0]        wait_cnt;
  logic [CNT_WIDTH-1:0]        gap_cnt;
  logic [2:0]                  cls;
  logic signed [IO_width-1:0]  freq_sel;
  logic signed [IO_width:0]    amp_d;

  // Sign-extend both operands first so the difference cannot wrap.
  assign amp_d = $signed({A_max[IO_width-1], A_max}) - $signed({A_min[IO_width-1], A_min});

  // Priority classifier: first matching rule wins.
  always_comb begin
    cls      = MT_UNK;
    freq_sel = '0;
    if (A_const && Freq_const) begin
      cls = MT_CW;
    end else if (!A_const && A_square && (A_edge_interv_homo < PSK_TH)) begin
      cls      = MT_PSK;
      freq_sel = A_freq;
    end else if (!A_const && A_square) begin
      cls      = MT_ASK;
      freq_sel = A_freq;
    end else if (!A_const && Freq_const) begin
      cls      = MT_AM;
      freq_sel = A_freq;
    end else if (A_const && !Freq_const && Freq_square) begin
      cls      = MT_FSK;
      freq_sel = F_freq;
    end else if (A_const && !Freq_const) begin
      cls      = MT_FM;
      freq_sel = F_freq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      gap_cnt      <= '0;
      meas_trig    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      mod_type     <= MT_UNK;
      mod_freq     <= '0;
      amp_pp       <= '0;
    end else begin
      meas_trig    <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start || (auto_en && gap_cnt == HOLD_TC)) begin
            state     <= TRIG;
            meas_trig <= 1'b1;
            busy      <= 1'b1;
            gap_cnt   <= '0;
          end else if (auto_en) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else begin
            gap_cnt <= '0;
          end
        end
        TRIG: begin
          wait_cnt <= '0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wait_cnt == SETTLE_TC) begin
            state <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            // Results land together with the valid pulse during DONE.
            state        <= DONE;
            mod_type     <= cls;
            mod_freq     <= freq_sel;
            amp_pp       <= amp_d;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          gap_cnt <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meas_sequencer.sv
// Bench for meas_sequencer: vector table through a scoreboard, plus auto,
// abort, reset and busy-start sequences.
module tb_meas_sequencer;
  localparam int W = 14;

  logic clk = 0, rst, start, auto_en, abort;
  logic A_const, A_square, Freq_const, Freq_square;
  logic signed [W-1:0] A_max, A_min, A_edge_interv_homo, A_freq, F_freq;
  logic meas_trig, busy, result_valid;
  logic [2:0] mod_type;
  logic signed [W-1:0] mod_freq;
  logic signed [W:0] amp_pp;

  meas_sequencer #(.IO_width(W), .CNT_WIDTH(32), .SETTLE_NUM(20), .HOLD_NUM(10), .PSK_DL(20)) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .abort(abort),
    .A_const(A_const), .A_square(A_square), .Freq_const(Freq_const), .Freq_square(Freq_square),
    .A_max(A_max), .A_min(A_min), .A_edge_interv_homo(A_edge_interv_homo),
    .A_freq(A_freq), .F_freq(F_freq), .meas_trig(meas_trig), .busy(busy),
    .mod_type(mod_type), .mod_freq(mod_freq), .amp_pp(amp_pp), .result_valid(result_valid));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit ac, as_, fc, fs;
    int homo, afreq, ffreq, amax, amin;
    int emt, emf, eap;
  } vec_t;

  typedef struct { int mt, mf, ap; } exp_t;

  vec_t vecs[10];
  exp_t exp_q[$];
  int errors = 0, checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    A_const = v.ac; A_square = v.as_; Freq_const = v.fc; Freq_square = v.fs;
    A_edge_interv_homo = v.homo[W-1:0];
    A_freq = v.afreq[W-1:0]; F_freq = v.ffreq[W-1:0];
    A_max = v.amax[W-1:0]; A_min = v.amin[W-1:0];
  endtask

  // Steps until result_valid; reports edges taken and stray triggers seen.
  task automatic wait_valid(output int n, output bit ok, output int trigs);
    n = 0; ok = 0; trigs = 0;
    for (int k = 0; k < 100; k++) begin
      step(); n++;
      if (meas_trig) trigs++;
      if (result_valid) begin ok = 1; break; end
    end
  endtask

  task automatic run_vec(input int i);
    int n, trigs;
    bit ok;
    exp_t e, got;
    apply(vecs[i]);
    e.mt = vecs[i].emt; e.mf = vecs[i].emf; e.ap = vecs[i].eap;
    exp_q.push_back(e);
    start = 1;
    step();
    start = 0;
    check($sformatf("v%0d_trig", i), int'(meas_trig), 1);
    wait_valid(n, ok, trigs);
    check($sformatf("v%0d_latency", i), ok ? n : -1, 22);
    check($sformatf("v%0d_single_trig", i), trigs, 0);
    if (ok && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check($sformatf("v%0d_mod_type", i), int'(mod_type), got.mt);
      check($sformatf("v%0d_mod_freq", i), int'(mod_freq), got.mf);
      check($sformatf("v%0d_amp_pp", i), int'(amp_pp), got.ap);
    end else begin
      check($sformatf("v%0d_scoreboard", i), exp_q.size(), 1);
      exp_q.delete();
    end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, trigs, rv;
    bit ok;
    int tt[$];
    //         ac as fc fs homo afreq ffreq  amax   amin  mt  mf     ap
    vecs[0] = '{1, 0, 1, 0,   0,  111,  222,   100,    40, 0,   0,     60};
    vecs[1] = '{0, 0, 1, 0,   0, 2000,    0,  5000, -3000, 1, 2000,  8000};
    vecs[2] = '{0, 1, 0, 0,  10,  300,    0,  1000,     0, 5, 300,   1000};
    vecs[3] = '{0, 1, 0, 0, 300,  300,    0,  1000,     0, 2, 300,   1000};
    vecs[4] = '{1, 0, 0, 1,   0,    0,  500,    10,    20, 4, 500,    -10};
    vecs[5] = '{1, 0, 0, 0,   0,    0,  700,     0,     0, 3, 700,      0};
    vecs[6] = '{0, 0, 0, 0,   0,   55,   66,  8191, -8192, 7,   0,  16383};
    vecs[7] = '{0, 1, 1, 0,  19,   77,    0, -8192,  8191, 5,  77, -16383};
    vecs[8] = '{0, 1, 1, 0,  20,   77,    0,     0,     0, 2,  77,      0};
    vecs[9] = '{0, 1, 0, 0,  -5,   88,    0,     0,     0, 5,  88,      0};

    rst = 1; start = 0; auto_en = 0; abort = 0;
    apply(vecs[0]);
    step(); step();
    check("rst_mod_type", int'(mod_type), 7);
    check("rst_mod_freq", int'(mod_freq), 0);
    check("rst_amp_pp", int'(amp_pp), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_trig", int'(meas_trig), 0);
    check("rst_valid", int'(result_valid), 0);
    rst = 0;
    step();

    for (int i = 0; i < 10; i++) run_vec(i);

    // Auto-repeat period and clean stop when auto_en drops mid-campaign.
    apply(vecs[1]);
    auto_en = 1;
    for (int k = 0; k < 120; k++) begin
      step();
      if (meas_trig) tt.push_back(cyc);
    end
    check("auto_trig_count_ge3", int'(tt.size() >= 3), 1);
    if (tt.size() >= 3) begin
      check("auto_period0", tt[1] - tt[0], 33);
      check("auto_period1", tt[2] - tt[1], 33);
    end
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (meas_trig) begin ok = 1; break; end
    end
    check("auto_next_trig", int'(ok), 1);
    for (int k = 0; k < 5; k++) step();
    auto_en = 0;
    wait_valid(n, ok, trigs);
    check("auto_off_completes", int'(ok), 1);
    check("auto_off_mod_type", int'(mod_type), 1);
    trigs = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (meas_trig) trigs++;
    end
    check("auto_off_no_retrig", trigs, 0);

    // Abort during WAIT with start held high.
    apply(vecs[4]);
    start = 1;
    step();
    check("abort_trig", int'(meas_trig), 1);
    for (int k = 0; k < 5; k++) step();
    abort = 1;
    step();
    abort = 0;
    check("abort_busy", int'(busy), 0);
    check("abort_no_valid", int'(result_valid), 0);
    check("abort_mod_type_held", int'(mod_type), 1);
    step();
    check("abort_retrig", int'(meas_trig), 1);
    start = 0;
    wait_valid(n, ok, trigs);
    check("abort_rerun_valid", ok ? n : -1, 22);
    check("abort_rerun_mod_type", int'(mod_type), 4);
    check("abort_rerun_mod_freq", int'(mod_freq), 500);
    step();

    // Abort coincident with wait terminal count.
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 20; k++) step();
    abort = 1;
    step();
    abort = 0;
    check("abort_tc_busy", int'(busy), 0);
    rv = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (result_valid) rv++;
    end
    check("abort_tc_no_valid", rv, 0);
    check("abort_tc_mod_type_held", int'(mod_type), 4);

    // Reset mid-campaign.
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 5; k++) step();
    rst = 1;
    step();
    check("midrst_mod_type", int'(mod_type), 7);
    check("midrst_mod_freq", int'(mod_freq), 0);
    check("midrst_amp_pp", int'(amp_pp), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_trig", int'(meas_trig), 0);
    rst = 0;
    step();

    // Start pulses while busy are ignored.
    apply(vecs[5]);
    start = 1;
    step();
    start = 0;
    trigs = 0; rv = 0;
    for (int k = 0; k < 30; k++) begin
      start = (k < 15) && (k % 3 == 0);
      step();
      if (meas_trig) trigs++;
      if (result_valid) rv++;
    end
    start = 0;
    check("busy_start_no_extra_trig", trigs, 0);
    check("busy_start_one_valid", rv, 1);
    check("busy_start_mod_type", int'(mod_type), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/meas_sequencer.md
Name: meas_sequencer

Overview:
- Sequences one demodulation measurement campaign on the judge/calculate datapath.
- Issues the single-cycle measurement trigger, then waits the worst-case statistics window of all measurement units.
- Captures the const/square flags, frequency and min/max results, and classifies the modulation type.
- Publishes one registered result set with a valid pulse; supports single-shot, auto-repeat and abort.

Parameters:
IO_width, 14, width of all numeric result inputs/outputs
CNT_WIDTH, 32, width of internal wait/gap counters
SETTLE_NUM, 36000, cycles waited after trigger before capture (20 ms at 1.8 MHz; covers the 16 ms judge windows plus margin); must be >=1
HOLD_NUM, 18000, idle cycles between campaigns in auto mode; must be >=1
PSK_DL, 20, A_edge_interv_homo below this value (with square envelope) classifies as PSK

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-shot request, level-sampled in IDLE only
auto_en  in  1  auto-repeat enable
abort  in  1  cancel current campaign
A_const, A_square, Freq_const, Freq_square  in  1 each  judge flags
A_max, A_min, A_edge_interv_homo, A_freq, F_freq  in  IO_width each  signed judge results
meas_trig  out  1  trigger pulse to measurement units
busy  out  1  high in any state other than IDLE
mod_type  out  3  0 CW, 1 AM, 2 ASK, 3 FM, 4 FSK, 5 PSK, 7 unknown
mod_freq  out  IO_width  selected modulating-frequency result
amp_pp  out  IO_width+1  A_max - A_min, signed, sign-extended before subtract
result_valid  out  1  one-cycle pulse when results update

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE; all counters 0; meas_trig=0, busy=0, result_valid=0, mod_type=7, mod_freq=0, amp_pp=0.
- All outputs are registered and decoded from the registered state.
- IDLE:
  - start=1 -> TRIG.
  - else if auto_en=1, gap counter increments; when it reaches HOLD_NUM-1 -> TRIG.
  - Gap counter clears on entry to IDLE and whenever auto_en=0.
- TRIG: meas_trig=1 for exactly this cycle; wait counter cleared -> WAIT.
- WAIT: wait counter increments each cycle; at SETTLE_NUM-1 -> CAPTURE.
- CAPTURE (one cycle):
  - Register all judge inputs.
  - Compute classification, first match wins:
    1. A_const & Freq_const -> CW.
    2. !A_const & A_square & A_edge_interv_homo < PSK_DL -> PSK.
    3. !A_const & A_square -> ASK.
    4. !A_const & Freq_const -> AM.
    5. A_const & !Freq_const & Freq_square -> FSK.
    6. A_const & !Freq_const -> FM.
    7. Otherwise unknown (7).
  - Then -> DONE.
- DONE (one cycle):
  - mod_type, mod_freq and amp_pp update.
  - mod_freq = A_freq for AM/ASK/PSK, F_freq for FM/FSK, 0 for CW/unknown.
  - result_valid=1 this cycle only -> IDLE.
- Latency: start sampled in IDLE at edge N gives meas_trig high in cycle N+1 and result_valid high in cycle N+SETTLE_NUM+3.
- busy=1 in TRIG, WAIT, CAPTURE, DONE.
- start is ignored while busy; no queuing.
- abort=1 in TRIG/WAIT/CAPTURE -> IDLE next cycle; no result_valid; outputs hold their previous values. In IDLE and DONE, abort is ignored.
- Simultaneous abort and wait-counter terminal count: abort wins.
- Simultaneous start and auto gap terminal count: single trigger.
- auto_en falling mid-campaign: the campaign completes; no further auto retrigger.
- rst mid-campaign: immediate return to reset values on that edge, meas_trig never stretched.
- amp_pp is computed at IO_width+1 bits, so the subtraction never overflows.

Test Plan:
- Reset, then SETTLE_NUM=20 and start pulse at edge N, inputs A_const=1, Freq_const=1 -> meas_trig high only in cycle N+1; result_valid in cycle N+23; mod_type=0, mod_freq=0.
- Inputs A_const=0, A_square=0, Freq_const=1, A_freq=2000, A_max=5000, A_min=-3000 -> mod_type=1, mod_freq=2000, amp_pp=8000.
- A_const=0, A_square=1, A_edge_interv_homo=10 -> PSK (5); same with homo=300 -> ASK (2). A_const=1, Freq_const=0, Freq_square=1, F_freq=500 -> FSK (4), mod_freq=500.
- auto_en=1, HOLD_NUM=10, SETTLE_NUM=20 -> meas_trig pulses exactly 33 cycles apart; deassert auto_en during WAIT -> that campaign completes, then no further trigger.
- abort during WAIT, with start held high throughout -> IDLE next cycle, no result_valid, prior mod_type unchanged; new trigger on the following cycle.
- rst asserted during WAIT -> all outputs return to reset values at that edge; start pulses during busy produce no extra meas_trig.
